// File: rtl/axi_bw_tester_if.sv
// AXI4 master bus bundle for the bandwidth tester.
// Full AW/W/B/AR/R signal set, 64-bit addresses.
interface axi_bw_tester_if #(
  parameter int DW = 512,
  parameter int IW = 4
);
  logic [IW-1:0]   awid;
  logic [63:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [IW-1:0]   arid;
  logic [63:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic [3:0]      arqos;
  logic            arvalid;
  logic            arready;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_bw_tester.sv
// AXI4 bandwidth tester: independent write and read
// burst engines with cycle timers and data checking.
module axi_bw_tester #(
  parameter int          DW          = 512,
  parameter int          IW          = 4,
  parameter int          BURST_BYTES = 4096,
  parameter int          MAX_OUT     = 8,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] burst_count,
  input  logic        start_write,
  input  logic        start_read,
  output logic        wr_busy,
  output logic        rd_busy,
  output logic        wr_done,
  output logic        rd_done,
  output logic [31:0] write_time,
  output logic [31:0] read_time,
  output logic [31:0] rd_mismatch,
  output logic [31:0] resp_err,
  axi_bw_tester_if.master m_axi
);
  localparam int          BEATS = BURST_BYTES / (DW / 8);
  localparam logic [7:0]  LEN   = 8'(BEATS - 1);
  localparam logic [2:0]  SIZE  = 3'($clog2(DW / 8));
  localparam logic [63:0] BB    = 64'(BURST_BYTES);
  localparam logic [31:0] MO    = 32'(MAX_OUT);

  typedef enum logic {IDLE, RUN} st_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

  st_t wr_st, rd_st;

  logic [31:0] wr_cnt, aw_sent, b_recv, w_bursts;
  logic [31:0] wk, wr_timer;
  logic [7:0]  w_beat;
  logic        aw_v, w_v;
  logic [63:0] aw_a;
  logic        wr_acc, aw_hs, w_hs, w_end;
  logic        b_hs, b_err, wr_fin;
  logic [31:0] aw_sent_n, b_recv_n, w_bursts_n;

  logic [31:0] rd_cnt, ar_sent, r_recv, rj, rd_timer;
  logic        ar_v;
  logic [63:0] ar_a;
  logic        rd_acc, ar_hs, r_hs, r_end;
  logic        r_err, r_bad, rd_fin;
  logic [31:0] ar_sent_n, r_recv_n;
  logic [32:0] err_sum;
  logic        unused_ok;

  assign m_axi.awid    = {IW{1'b0}};
  assign m_axi.awlen   = LEN;
  assign m_axi.awsize  = SIZE;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awvalid = aw_v;
  assign m_axi.awaddr  = aw_a;
  assign m_axi.wdata   = {(DW/32){wk}};
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = (w_beat == LEN);
  assign m_axi.wvalid  = w_v;
  assign m_axi.bready  = wr_busy;
  assign m_axi.arid    = {IW{1'b0}};
  assign m_axi.arlen   = LEN;
  assign m_axi.arsize  = SIZE;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arqos   = 4'd0;
  assign m_axi.arvalid = ar_v;
  assign m_axi.araddr  = ar_a;
  assign m_axi.rready  = rd_busy;

  assign unused_ok = ^{m_axi.bid, m_axi.rid};

  assign wr_busy    = (wr_st == RUN);
  assign wr_acc     = start_write && !wr_busy
                   && (burst_count != 32'd0);
  assign aw_hs      = aw_v && m_axi.awready;
  assign w_hs       = w_v && m_axi.wready;
  assign w_end      = w_hs && (w_beat == LEN);
  assign b_hs       = wr_busy && m_axi.bvalid;
  assign b_err      = b_hs && (m_axi.bresp != 2'b00);
  assign aw_sent_n  = aw_sent + 32'(aw_hs);
  assign b_recv_n   = b_recv + 32'(b_hs);
  assign w_bursts_n = w_bursts + 32'(w_end);
  assign wr_fin     = b_hs && (b_recv_n == wr_cnt);

  assign rd_busy   = (rd_st == RUN);
  assign rd_acc    = start_read && !rd_busy
                  && (burst_count != 32'd0);
  assign ar_hs     = ar_v && m_axi.arready;
  assign r_hs      = rd_busy && m_axi.rvalid;
  assign r_end     = r_hs && m_axi.rlast;
  assign r_err     = r_hs && (m_axi.rresp != 2'b00);
  assign r_bad     = r_hs
                  && (m_axi.rdata != {(DW/32){rj}});
  assign ar_sent_n = ar_sent + 32'(ar_hs);
  assign r_recv_n  = r_recv + 32'(r_end);
  assign rd_fin    = r_end && (r_recv_n == rd_cnt);

  assign err_sum = {1'b0, (wr_acc || rd_acc)
                          ? 32'd0 : resp_err}
                 + 33'(b_err) + 33'(r_err);

  // Write engine: AW issue window, W beats, B collection, timer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_st      <= IDLE;
      wr_cnt     <= '0;
      aw_sent    <= '0;
      b_recv     <= '0;
      w_bursts   <= '0;
      wk         <= '0;
      w_beat     <= '0;
      wr_timer   <= '0;
      aw_v       <= 1'b0;
      aw_a       <= '0;
      w_v        <= 1'b0;
      write_time <= '0;
      wr_done    <= 1'b0;
    end else begin
      wr_done <= wr_fin;
      if (wr_acc) begin
        wr_st    <= RUN;
        wr_cnt   <= burst_count;
        aw_sent  <= '0;
        b_recv   <= '0;
        w_bursts <= '0;
        wk       <= '0;
        w_beat   <= '0;
        wr_timer <= '0;
        aw_v     <= 1'b1;
        aw_a     <= BASE_ADDR;
        w_v      <= 1'b0;
      end else if (wr_busy) begin
        aw_sent  <= aw_sent_n;
        b_recv   <= b_recv_n;
        w_bursts <= w_bursts_n;
        wr_timer <= sat_inc(wr_timer);
        if (w_hs) begin
          wk     <= wk + 32'd1;
          w_beat <= w_end ? 8'd0 : w_beat + 8'd1;
        end
        if (wr_fin) begin
          wr_st      <= IDLE;
          write_time <= sat_inc(wr_timer);
          aw_v       <= 1'b0;
          w_v        <= 1'b0;
        end else begin
          aw_v <= (aw_sent_n < wr_cnt)
               && ((aw_sent_n - b_recv_n) < MO);
          aw_a <= BASE_ADDR + 64'(aw_sent_n) * BB;
          w_v  <= (w_bursts_n < aw_sent_n);
        end
      end
    end
  end

  // Read engine: AR issue window, R checking, timer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_st       <= IDLE;
      rd_cnt      <= '0;
      ar_sent     <= '0;
      r_recv      <= '0;
      rj          <= '0;
      rd_timer    <= '0;
      ar_v        <= 1'b0;
      ar_a        <= '0;
      read_time   <= '0;
      rd_done     <= 1'b0;
      rd_mismatch <= '0;
    end else begin
      rd_done <= rd_fin;
      if (rd_acc) begin
        rd_st       <= RUN;
        rd_cnt      <= burst_count;
        ar_sent     <= '0;
        r_recv      <= '0;
        rj          <= '0;
        rd_timer    <= '0;
        ar_v        <= 1'b1;
        ar_a        <= BASE_ADDR;
        rd_mismatch <= '0;
      end else if (rd_busy) begin
        ar_sent  <= ar_sent_n;
        r_recv   <= r_recv_n;
        rd_timer <= sat_inc(rd_timer);
        if (r_hs) rj <= rj + 32'd1;
        if (r_bad) rd_mismatch <= sat_inc(rd_mismatch);
        if (rd_fin) begin
          rd_st     <= IDLE;
          read_time <= sat_inc(rd_timer);
          ar_v      <= 1'b0;
        end else begin
          ar_v <= (ar_sent_n < rd_cnt)
               && ((ar_sent_n - r_recv_n) < MO);
          ar_a <= BASE_ADDR + 64'(ar_sent_n) * BB;
        end
      end
    end
  end

  // Shared response-error counter, fed by both engines
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) resp_err <= '0;
    else resp_err <= err_sum[32] ? '1 : err_sum[31:0];
  end
endmodule

// File: tb/tb_axi_bw_tester.sv
// Bench for axi_bw_tester: scenario table plus
// directed sequences for stall, ignore and abort cases.
module tb_axi_bw_tester;
  localparam logic [31:0] NONE = 32'hFFFFFFFF;

  typedef struct {
    logic [31:0] n;
    bit          wr;
    bit          rd;
    bit          slow;
    logic [31:0] cor;
    logic [31:0] rerr;
    logic [31:0] berr;
    logic [31:0] beats;
    logic [31:0] mis;
    logic [31:0] err;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] burst_count = '0;
  logic        start_write = 1'b0;
  logic        start_read = 1'b0;
  logic        wr_busy, rd_busy, wr_done, rd_done;
  logic [31:0] write_time, read_time;
  logic [31:0] rd_mismatch, resp_err;

  int total = 0;
  int bad = 0;

  bit          slow = 1'b0;
  bit          bhold = 1'b0;
  logic [31:0] cor = NONE;
  logic [31:0] rerr = NONE;
  logic [31:0] berr = NONE;

  axi_bw_tester_if #(.DW(64), .IW(4)) bus ();

  axi_bw_tester #(
    .DW(64), .IW(4), .BURST_BYTES(64),
    .MAX_OUT(2), .BASE_ADDR(64'h0)
  ) dut (
    .clk(clk), .resetn(resetn),
    .burst_count(burst_count),
    .start_write(start_write),
    .start_read(start_read),
    .wr_busy(wr_busy), .rd_busy(rd_busy),
    .wr_done(wr_done), .rd_done(rd_done),
    .write_time(write_time), .read_time(read_time),
    .rd_mismatch(rd_mismatch), .resp_err(resp_err),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  logic aw_hs, w_hs, wl_hs, b_hs;
  logic ar_hs, r_hs, rl_hs, en, tick;
  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid & bus.wready;
  assign wl_hs = w_hs & bus.wlast;
  assign b_hs  = bus.bvalid & bus.bready;
  assign ar_hs = bus.arvalid & bus.arready;
  assign r_hs  = bus.rvalid & bus.rready;
  assign rl_hs = r_hs & bus.rlast;
  assign en    = !slow || tick;
  assign bus.bid = '0;
  assign bus.rid = '0;

  logic [31:0] b_pend, bcnt, ar_pend, sj, nsj;
  logic [7:0]  rbeat, nrb;
  assign nsj = sj + 32'(r_hs);
  assign nrb = r_hs ? (bus.rlast ? 8'd0 : rbeat + 8'd1)
                    : rbeat;

  // Slave model: ready throttling, B queue, pattern R data
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick        <= 1'b0;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.arready <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= 2'd0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= 2'd0;
      bus.rlast   <= 1'b0;
      b_pend      <= '0;
      bcnt        <= '0;
      ar_pend     <= '0;
      sj          <= '0;
      rbeat       <= '0;
    end else begin
      tick        <= ~tick;
      bus.awready <= en;
      bus.wready  <= en;
      bus.arready <= en;
      b_pend <= b_pend + 32'(wl_hs) - 32'(b_hs);
      bcnt   <= bcnt + 32'(b_hs);
      bus.bvalid <= !bhold && en
        && ((b_pend + 32'(wl_hs) - 32'(b_hs)) != 0);
      bus.bresp <= ((bcnt + 32'(b_hs)) == berr)
                   ? 2'd2 : 2'd0;
      ar_pend <= ar_pend + 32'(ar_hs) - 32'(rl_hs);
      sj      <= nsj;
      rbeat   <= nrb;
      bus.rvalid <= en
        && ((ar_pend + 32'(ar_hs) - 32'(rl_hs)) != 0);
      bus.rdata <= {2{nsj}}
                 ^ ((nsj == cor) ? 64'd1 : 64'd0);
      bus.rresp <= (nsj == rerr) ? 2'd2 : 2'd0;
      bus.rlast <= (nrb == 8'd7);
    end
  end

  logic [31:0] aw_n, b_n, w_n, ar_n, rb_n, r_n;
  logic [31:0] aw_bad, ar_bad, wd_bad, wl_bad, ot_bad;
  logic [31:0] wcyc, rcyc, wdn, rdn;

  // Monitor: independent expectations for every handshake
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_n <= '0; b_n <= '0; w_n <= '0;
      ar_n <= '0; rb_n <= '0; r_n <= '0;
      aw_bad <= '0; ar_bad <= '0; wd_bad <= '0;
      wl_bad <= '0; ot_bad <= '0;
      wcyc <= '0; rcyc <= '0; wdn <= '0; rdn <= '0;
    end else begin
      if (w_hs) begin
        if (bus.wdata != {2{w_n}}
            || bus.wstrb != 8'hFF
            || (w_n / 8) >= aw_n)
          wd_bad <= wd_bad + 1;
        if (bus.wlast != (w_n[2:0] == 3'd7))
          wl_bad <= wl_bad + 1;
        w_n <= w_n + 1;
      end
      if (aw_hs) begin
        if (bus.awaddr != 64'(aw_n) * 64'd64
            || bus.awlen != 8'd7 || bus.awsize != 3'd3
            || bus.awburst != 2'd1 || bus.awid != 4'd0)
          aw_bad <= aw_bad + 1;
        aw_n <= aw_n + 1;
      end
      if (ar_hs) begin
        if (bus.araddr != 64'(ar_n) * 64'd64
            || bus.arlen != 8'd7 || bus.arsize != 3'd3
            || bus.arburst != 2'd1 || bus.arid != 4'd0)
          ar_bad <= ar_bad + 1;
        ar_n <= ar_n + 1;
      end
      if ((bus.awvalid && (aw_n - b_n) >= 2)
          || (bus.arvalid && (ar_n - rb_n) >= 2))
        ot_bad <= ot_bad + 1;
      if (b_hs) b_n <= b_n + 1;
      if (rl_hs) rb_n <= rb_n + 1;
      if (r_hs) r_n <= r_n + 1;
      if (wr_busy) wcyc <= wcyc + 1;
      if (rd_busy) rcyc <= rcyc + 1;
      if (wr_done) wdn <= wdn + 1;
      if (rd_done) rdn <= rdn + 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_flags"}, 64'({wr_busy, rd_busy,
        wr_done, rd_done, bus.awvalid, bus.wvalid,
        bus.bready, bus.arvalid, bus.rready}), 64'd0);
    chk({tag, "_times"}, {write_time, read_time}, 64'd0);
    chk({tag, "_cnts"}, {rd_mismatch, resp_err}, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_zero(tag);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_wr(input string nm);
    int c = 0;
    while (wdn == 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 64'(c < 3000), 64'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c = 0;
    string s;
    s = $sformatf("v%0d", idx);
    slow = v.slow; bhold = 1'b0;
    cor = v.cor; rerr = v.rerr; berr = v.berr;
    do_reset({s, "_rst"});
    resetn = 1'b1;
    burst_count = v.n;
    start_write = v.wr;
    start_read = v.rd;
    @(negedge clk);
    start_write = 1'b0;
    start_read = 1'b0;
    chk({s, "_busy"}, 64'({wr_busy, rd_busy}),
        64'({v.wr, v.rd}));
    while (!((!v.wr || wdn != 0) && (!v.rd || rdn != 0))
           && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({s, "_done_wait"}, 64'(c < 3000), 64'd1);
    repeat (5) @(negedge clk);
    if (v.wr) begin
      chk({s, "_aw_n"}, aw_n, v.n);
      chk({s, "_aw_bad"}, aw_bad, 0);
      chk({s, "_w_beats"}, w_n, v.beats);
      chk({s, "_w_data"}, wd_bad, 0);
      chk({s, "_w_last"}, wl_bad, 0);
      chk({s, "_wr_done"}, wdn, 1);
      chk({s, "_wr_time"}, write_time, wcyc);
    end
    if (v.rd) begin
      chk({s, "_ar_n"}, ar_n, v.n);
      chk({s, "_ar_bad"}, ar_bad, 0);
      chk({s, "_r_beats"}, r_n, v.beats);
      chk({s, "_rd_done"}, rdn, 1);
      chk({s, "_rd_time"}, read_time, rcyc);
      chk({s, "_mismatch"}, rd_mismatch, v.mis);
    end
    chk({s, "_outstanding"}, ot_bad, 0);
    chk({s, "_resp_err"}, resp_err, v.err);
    chk({s, "_idle"}, 64'({wr_busy, rd_busy}), 64'd0);
  endtask

  vec_t vt[5];

  initial begin
    int c;
    vt[0] = '{32'd4, 1'b1, 1'b0, 1'b0, NONE, NONE,
              NONE, 32'd32, 32'd0, 32'd0};
    vt[1] = '{32'd4, 1'b0, 1'b1, 1'b0, 32'd9, 32'd20,
              NONE, 32'd32, 32'd1, 32'd1};
    vt[2] = '{32'd4, 1'b1, 1'b1, 1'b1, NONE, NONE,
              NONE, 32'd32, 32'd0, 32'd0};
    vt[3] = '{32'd1, 1'b1, 1'b1, 1'b0, NONE, 32'd3,
              32'd0, 32'd8, 32'd0, 32'd2};
    vt[4] = '{32'd3, 1'b0, 1'b1, 1'b1, 32'd0, NONE,
              NONE, 32'd24, 32'd1, 32'd0};

    for (int i = 0; i < 5; i++) run_vec(vt[i], i);

    // B withheld: AW must stop at two outstanding
    slow = 1'b0; cor = NONE; rerr = NONE; berr = NONE;
    bhold = 1'b1;
    do_reset("hold_rst");
    resetn = 1'b1;
    burst_count = 32'd4;
    start_write = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
    repeat (40) @(negedge clk);
    chk("hold_aw_n", aw_n, 2);
    chk("hold_awvalid", 64'(bus.awvalid), 64'd0);
    chk("hold_w_beats", w_n, 16);
    bhold = 1'b0;
    wait_wr("hold_done_wait");
    chk("hold_aw_final", aw_n, 4);
    chk("hold_wr_done", wdn, 1);
    chk("hold_outstanding", ot_bad, 0);
    chk("hold_w_data", wd_bad, 0);

    // Ignored starts: zero count, then restart while busy
    do_reset("ign_rst");
    resetn = 1'b1;
    burst_count = 32'd0;
    start_write = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
    chk("ign_zero_busy", 64'(wr_busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("ign_zero_aw", {aw_n, 31'd0, bus.awvalid}, 64'd0);
    burst_count = 32'd4;
    start_write = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
    c = 0;
    while (w_n < 10 && c < 500) begin
      @(negedge clk);
      c++;
    end
    burst_count = 32'd2;
    start_write = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
    wait_wr("ign_done_wait");
    chk("ign_aw_n", aw_n, 4);
    chk("ign_aw_bad", aw_bad, 0);
    chk("ign_w_beats", w_n, 32);
    chk("ign_w_data", wd_bad, 0);
    chk("ign_wr_done", wdn, 1);

    // Reset during burst 2 data, then a fresh test
    do_reset("abort_rst0");
    resetn = 1'b1;
    burst_count = 32'd4;
    start_write = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
    c = 0;
    while (w_n < 18 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("abort_reach_b2", 64'(w_n >= 18 && w_n < 24),
        64'd1);
    resetn = 1'b0;
    #1;
    check_reset_zero("abort_mid");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_quiet", {wdn, 31'd0, wr_busy}, 64'd0);
    start_write = 1'b1;
    @(negedge clk);
    start_write = 1'b0;
    wait_wr("abort_done_wait");
    chk("abort_aw_bad", aw_bad, 0);
    chk("abort_w_data", wd_bad, 0);
    chk("abort_w_beats", w_n, 32);
    chk("abort_wr_done", wdn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
